// File: rtl/n_clic_pend_arb_pkg.sv
// n_clic_pend_arb_pkg: source count and arbiter state type shared by the pend front end.
package config_pkg;
  localparam int NumPendSrc = 8;
endpackage

package decoder_pkg;
  typedef enum logic {PA_IDLE, PA_OFFER} pend_arb_state_t;
endpackage

// File: rtl/n_clic_pend_arb_rr_pick.sv
// rr_pick: combinational round-robin search over req starting at rr_ptr.
module rr_pick #(
  parameter int NumSrc   = 8,
  parameter int VecWidth = $clog2(NumSrc)
) (
  input  logic [NumSrc-1:0]   req,
  input  logic [VecWidth-1:0] rr_ptr,
  output logic                any,
  output logic [VecWidth-1:0] winner
);
  logic [VecWidth-1:0] idx;
  assign any = |req;
  // Scanning from the far end lets the closest requester at or after rr_ptr overwrite the rest.
  always_comb begin
    winner = '0;
    idx = '0;
    for (int k = NumSrc - 1; k >= 0; k--) begin
      idx = VecWidth'((int'(rr_ptr) + k) % NumSrc);
      if (req[idx]) winner = idx;
    end
  end
endmodule

// File: rtl/n_clic_pend_arb.sv
// n_clic_pend_arb: edge/level interrupt capture with round-robin pend delivery to n_clic.
// Define N_CLIC_PEND_LOST_EN to build the sticky per-source lost-event flags.
module n_clic_pend_arb
  import config_pkg::*, decoder_pkg::*;
#(
  parameter int NumSrc   = NumPendSrc,
  parameter int VecWidth = $clog2(NumSrc)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NumSrc-1:0]   src_irq,
  input  logic [NumSrc-1:0]   src_en,
  input  logic [NumSrc-1:0]   src_edge,
  output logic                pend_valid,
  output logic [VecWidth-1:0] pend_vec,
  input  logic                pend_ready,
  output logic [NumSrc-1:0]   lost,
  input  logic [NumSrc-1:0]   lost_clr
);
  pend_arb_state_t     state_q;
  logic [NumSrc-1:0]   src_q, req_q, req_d, ev, gnt;
  logic                any, pend_valid_q;
  logic [VecWidth-1:0] winner, pend_vec_q, rr_ptr_q, rr_ptr_d;

  rr_pick #(.NumSrc(NumSrc), .VecWidth(VecWidth)) u_rr_pick (
    .req(req_q), .rr_ptr(rr_ptr_q), .any(any), .winner(winner)
  );

  assign ev       = src_en & src_irq & ~(src_edge & src_q);
  assign gnt      = {NumSrc{state_q == PA_IDLE && any}} & (NumSrc'(1) << winner);
  // A fresh event outranks the grant so a re-asserting source is not swallowed.
  assign req_d    = src_en & (ev | (req_q & ~gnt));
  assign rr_ptr_d = (pend_vec_q == VecWidth'(NumSrc - 1)) ? '0 : pend_vec_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      src_q <= '0;
      req_q <= '0;
    end else begin
      src_q <= src_irq;
      req_q <= req_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= PA_IDLE;
      pend_valid_q <= 1'b0;
      pend_vec_q   <= '0;
      rr_ptr_q     <= '0;
    end else if (state_q == PA_IDLE) begin
      if (any) begin
        state_q      <= PA_OFFER;
        pend_valid_q <= 1'b1;
        pend_vec_q   <= winner;
      end
    end else if (pend_ready) begin
      state_q      <= PA_IDLE;
      pend_valid_q <= 1'b0;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign pend_valid = pend_valid_q;
  assign pend_vec   = pend_vec_q;

`ifdef N_CLIC_PEND_LOST_EN
  logic [NumSrc-1:0] lost_q;
  always_ff @(posedge clk) begin
    if (!reset) lost_q <= '0;
    else lost_q <= (ev & src_edge & req_q & ~gnt) | (lost_q & ~lost_clr);
  end
  assign lost = lost_q;
`else
  logic unused_lost_clr;
  assign unused_lost_clr = ^lost_clr;
  assign lost = '0;
`endif
endmodule

// File: tb/tb_n_clic_pend_arb.sv
// tb_n_clic_pend_arb: directed vectors for capture, round-robin order, hold, lost and reset.
module tb_n_clic_pend_arb;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] src_irq = '0, src_en = 8'hff, src_edge = 8'hff, lost, lost_clr = '0;
  logic       pend_valid, pend_ready = 1'b0;
  logic [2:0] pend_vec;
  int checks = 0, errors = 0;
`ifdef N_CLIC_PEND_LOST_EN
  localparam logic LostEn = 1'b1;
`else
  localparam logic LostEn = 1'b0;
`endif

  n_clic_pend_arb dut (
    .clk(clk), .reset(reset), .src_irq(src_irq), .src_en(src_en), .src_edge(src_edge),
    .pend_valid(pend_valid), .pend_vec(pend_vec), .pend_ready(pend_ready),
    .lost(lost), .lost_clr(lost_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic rst_pulse();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  int v3[3] = '{0, 2, 7};
  int v5[4] = '{1, 5, 1, 1};

  initial begin
    tick();
    tick();
    chk("rst_valid", 32'(pend_valid), 0);
    chk("rst_vec", 32'(pend_vec), 0);
    chk("rst_lost", 32'(lost), 0);
    chk("rst_ptr", 32'(dut.rr_ptr_q), 0);
    // single edge on source 4
    reset = 1'b1;
    src_irq = 8'h10;
    tick();
    chk("lat_k", 32'(pend_valid), 0);
    tick();
    chk("lat_valid", 32'(pend_valid), 1);
    chk("lat_vec", 32'(pend_vec), 4);
    pend_ready = 1'b1;
    tick();
    chk("lat_hs", 32'(pend_valid), 0);
    // simultaneous edges on 0, 2, 7
    src_irq = '0;
    rst_pulse();
    src_irq = 8'h85;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rr_valid", 32'(pend_valid), 1);
      chk("rr_vec", 32'(pend_vec), 32'(v3[i]));
      tick();
      chk("rr_gap", 32'(pend_valid), 0);
    end
    chk("rr_ptr_wrap", 32'(dut.rr_ptr_q), 0);
    // hold offer of 2 while source 2 re-edges
    pend_ready = 1'b0;
    src_irq = '0;
    tick();
    src_irq = 8'h04;
    tick();
    tick();
    chk("hold_valid", 32'(pend_valid), 1);
    for (int i = 0; i < 5; i++) begin
      src_irq = (i == 0) ? 8'h00 : 8'h04;
      tick();
      chk("hold_vec", 32'(pend_vec), 2);
      chk("hold_v", 32'(pend_valid), 1);
    end
    chk("hold_lost", 32'(lost), 0);
    pend_ready = 1'b1;
    tick();
    chk("hold_hs", 32'(pend_valid), 0);
    tick();
    chk("hold_again_v", 32'(pend_valid), 1);
    chk("hold_again_vec", 32'(pend_vec), 2);
    tick();
    chk("hold_again_hs", 32'(pend_valid), 0);
    chk("hold_lost2", 32'(lost), 0);
    // two edges on 3 behind a held offer of 6
    pend_ready = 1'b0;
    src_irq = 8'h40;
    tick();
    tick();
    chk("lost_offer6", 32'(pend_vec), 6);
    src_irq = 8'h48;
    tick();
    src_irq = 8'h40;
    tick();
    src_irq = 8'h48;
    tick();
    chk("lost_set", 32'(lost), LostEn ? 32'h8 : 32'h0);
    lost_clr = 8'h08;
    tick();
    lost_clr = '0;
    chk("lost_clr", 32'(lost), 0);
    pend_ready = 1'b1;
    tick();
    chk("lost_hs6", 32'(pend_valid), 0);
    tick();
    chk("lost_offer3_v", 32'(pend_valid), 1);
    chk("lost_offer3", 32'(pend_vec), 3);
    tick();
    chk("lost_hs3", 32'(pend_valid), 0);
    // level source 1 against edge source 5
    src_irq = '0;
    rst_pulse();
    src_edge = 8'hfd;
    src_irq = 8'h22;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("lvl_valid", 32'(pend_valid), 1);
      chk("lvl_vec", 32'(pend_vec), 32'(v5[i]));
      if (i == 3) src_en = 8'hfd;
      tick();
      chk("lvl_gap", 32'(pend_valid), 0);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("lvl_off", 32'(pend_valid), 0);
    end
    // reset while offering 6
    src_en = 8'hff;
    src_edge = 8'hff;
    src_irq = '0;
    pend_ready = 1'b0;
    tick();
    src_irq = 8'h40;
    tick();
    tick();
    chk("rmo_valid", 32'(pend_valid), 1);
    chk("rmo_vec", 32'(pend_vec), 6);
    reset = 1'b0;
    tick();
    chk("rmo_drop", 32'(pend_valid), 0);
    chk("rmo_state", 32'(dut.state_q), 32'(decoder_pkg::PA_IDLE));
    reset = 1'b1;
    tick();
    chk("rmo_k", 32'(pend_valid), 0);
    tick();
    chk("rmo_fresh_v", 32'(pend_valid), 1);
    chk("rmo_fresh_vec", 32'(pend_vec), 6);
    pend_ready = 1'b1;
    tick();
    chk("rmo_hs", 32'(pend_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
